// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states
// and the divide-by-zero quotient pattern.
package mult_div_unit_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } md_state_e;

  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/mult_div_unit_if.sv
// Operand/result bundle between the pipeline (master) and the mult/div unit (slave).
interface mult_div_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] mt_data;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, operand_a, operand_b, mthi, mtlo, mt_data,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, operand_a, operand_b, mthi, mtlo, mt_data,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with HI/LO registers: magnitudes are processed in a
// shared {acc, sh} shift register for ITER cycles, then signs are fixed in one cycle.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic            clk,
  input  logic            reset,
  mult_div_unit_if.slave  bus
);

  localparam int CNT_W = $clog2(ITER + 1);

  md_state_e        state_q, state_d;
  md_op_e           op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] a_raw_q, a_raw_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             neg_q, neg_d;
  logic             rsign_q, rsign_d;
  logic             div0_q, div0_d;
  logic             done_q, done_d;

  logic             a_neg, b_neg;
  logic [WIDTH:0]   add_w, rem_sh, diff;
  logic [2*WIDTH-1:0] prod;

  function automatic logic [WIDTH-1:0] md_sign_fix(input logic [WIDTH-1:0] v,
                                                   input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_MULT;
      cnt_q   <= '0;
      acc_q   <= '0;
      sh_q    <= '0;
      opb_q   <= '0;
      a_raw_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      neg_q   <= 1'b0;
      rsign_q <= 1'b0;
      div0_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sh_q    <= sh_d;
      opb_q   <= opb_d;
      a_raw_q <= a_raw_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      neg_q   <= neg_d;
      rsign_q <= rsign_d;
      div0_q  <= div0_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sh_d    = sh_q;
    opb_d   = opb_q;
    a_raw_d = a_raw_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    neg_d   = neg_q;
    rsign_d = rsign_q;
    div0_d  = div0_q;
    done_d  = 1'b0;

    a_neg  = ~bus.op[0] & bus.operand_a[WIDTH-1];
    b_neg  = ~bus.op[0] & bus.operand_b[WIDTH-1];
    // Multiply adds the multiplicand when the multiplier LSB is set; divide trial-subtracts.
    add_w  = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
    rem_sh = {acc_q, sh_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, opb_q};
    prod   = neg_q ? (~{acc_q, sh_q} + 1'b1) : {acc_q, sh_q};

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_d    = md_op_e'(bus.op);
          sh_d    = md_sign_fix(bus.operand_a, a_neg);
          opb_d   = md_sign_fix(bus.operand_b, b_neg);
          acc_d   = '0;
          neg_d   = a_neg ^ b_neg;
          rsign_d = a_neg;
          a_raw_d = bus.operand_a;
          div0_d  = (bus.operand_b == '0);
          cnt_d   = '0;
          state_d = S_CALC;
        end else begin
          if (bus.mthi) hi_d = bus.mt_data;
          if (bus.mtlo) lo_d = bus.mt_data;
        end
      end
      S_CALC: begin
        if (op_q[1]) begin
          acc_d = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
          sh_d  = {sh_q[WIDTH-2:0], ~diff[WIDTH]};
        end else begin
          acc_d = add_w[WIDTH:1];
          sh_d  = {add_w[0], sh_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ITER - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (op_q[1]) begin
          if (div0_q) begin
            hi_d = a_raw_q;
            lo_d = WIDTH'(DIV0_LO);
          end else begin
            hi_d = md_sign_fix(acc_q, rsign_q);
            lo_d = md_sign_fix(sh_q, neg_q);
          end
        end else begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: latency, signed/unsigned results,
// divide-by-zero, ignored inputs, MTHI/MTLO and mid-operation reset.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mult_div_unit_if #(.WIDTH(32)) bus ();

  mult_div_unit #(.WIDTH(32), .ITER(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    bus.op        = o;
    bus.operand_a = a;
    bus.operand_b = b;
    bus.start     = 1'b1;
    step();
    bus.start     = 1'b0;
  endtask

  // Counts edges from just after the launch edge until done, and busy cycles seen.
  task automatic wait_done(output int n, output int busy_cnt);
    n = 0;
    busy_cnt = 0;
    while (!bus.done && n < 100) begin
      if (bus.busy) busy_cnt++;
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.done); end
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h exp 00000000", bus.hi); end
    checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h exp 00000000", bus.lo); end
  endtask

  task automatic test_multu_max();
    int n, bc;
    launch(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL multu_busy_after_start got %b exp 1", bus.busy); end
    wait_done(n, bc);
    checks++; if (n !== 33) begin errors++; $display("FAIL multu_latency got %0d exp 33", n); end
    checks++; if (bc !== 33) begin errors++; $display("FAIL multu_busy_cycles got %0d exp 33", bc); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL multu_busy_at_done got %b exp 0", bus.busy); end
    checks++; if (bus.hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi got %h exp fffffffe", bus.hi); end
    checks++; if (bus.lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo got %h exp 00000001", bus.lo); end
    step();
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL multu_done_pulse got %b exp 0", bus.done); end
  endtask

  task automatic test_mult_signed();
    int n, bc;
    launch(OP_MULT, 32'hFFFF_FFFD, 32'h0000_0005);
    wait_done(n, bc);
    checks++; if (n !== 33) begin errors++; $display("FAIL mult_latency got %0d exp 33", n); end
    checks++; if (bus.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h exp ffffffff", bus.hi); end
    checks++; if (bus.lo !== 32'hFFFF_FFF1) begin errors++; $display("FAIL mult_lo got %h exp fffffff1", bus.lo); end
    step();
    launch(OP_MULT, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
    wait_done(n, bc);
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL mult_negneg_hi got %h exp 00000000", bus.hi); end
    checks++; if (bus.lo !== 32'h0000_0006) begin errors++; $display("FAIL mult_negneg_lo got %h exp 00000006", bus.lo); end
    step();
  endtask

  task automatic test_divide();
    int n, bc;
    launch(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_done(n, bc);
    checks++; if (n !== 33) begin errors++; $display("FAIL div_latency got %0d exp 33", n); end
    checks++; if (bus.lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_quot got %h exp fffffffd", bus.lo); end
    checks++; if (bus.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_rem got %h exp ffffffff", bus.hi); end
    step();
    launch(OP_DIV, 32'h0000_0007, 32'hFFFF_FFFE);
    wait_done(n, bc);
    checks++; if (bus.lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_posneg_quot got %h exp fffffffd", bus.lo); end
    checks++; if (bus.hi !== 32'h0000_0001) begin errors++; $display("FAIL div_posneg_rem got %h exp 00000001", bus.hi); end
    step();
    launch(OP_DIVU, 32'd1000, 32'd3);
    wait_done(n, bc);
    checks++; if (bus.lo !== 32'd333) begin errors++; $display("FAIL divu_quot got %h exp 0000014d", bus.lo); end
    checks++; if (bus.hi !== 32'd1) begin errors++; $display("FAIL divu_rem got %h exp 00000001", bus.hi); end
    step();
  endtask

  task automatic test_div_boundaries();
    int n, bc;
    launch(OP_DIVU, 32'd100, 32'd0);
    wait_done(n, bc);
    checks++; if (n !== 33) begin errors++; $display("FAIL divu0_latency got %0d exp 33", n); end
    checks++; if (bus.hi !== 32'h0000_0064) begin errors++; $display("FAIL divu0_hi got %h exp 00000064", bus.hi); end
    checks++; if (bus.lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu0_lo got %h exp ffffffff", bus.lo); end
    step();
    launch(OP_DIV, 32'hFFFF_FFFB, 32'd0);
    wait_done(n, bc);
    checks++; if (bus.hi !== 32'hFFFF_FFFB) begin errors++; $display("FAIL div0_hi got %h exp fffffffb", bus.hi); end
    checks++; if (bus.lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0_lo got %h exp ffffffff", bus.lo); end
    step();
    launch(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(n, bc);
    checks++; if (bus.lo !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo got %h exp 80000000", bus.lo); end
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL div_ovf_hi got %h exp 00000000", bus.hi); end
    step();
  endtask

  task automatic test_ignored_inputs();
    int cyc, extra_done, extra_busy;
    logic [31:0] hi_prev, lo_prev;
    hi_prev = bus.hi;
    lo_prev = bus.lo;
    launch(OP_MULTU, 32'd6, 32'd7);
    cyc = 1;
    while (!bus.done && cyc < 100) begin
      if (cyc == 20) begin
        checks++; if (bus.hi !== hi_prev) begin errors++; $display("FAIL stale_hi got %h exp %h", bus.hi, hi_prev); end
        checks++; if (bus.lo !== lo_prev) begin errors++; $display("FAIL stale_lo got %h exp %h", bus.lo, lo_prev); end
      end
      bus.start     = (cyc == 10);
      bus.op        = OP_DIVU;
      bus.operand_a = 32'd9;
      bus.operand_b = 32'd3;
      bus.mthi      = (cyc == 12);
      bus.mt_data   = 32'h1234;
      step();
      cyc++;
    end
    bus.start = 1'b0;
    bus.mthi  = 1'b0;
    checks++; if (cyc !== 34) begin errors++; $display("FAIL ign_latency got %0d exp 34", cyc); end
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL ign_hi got %h exp 00000000", bus.hi); end
    checks++; if (bus.lo !== 32'd42) begin errors++; $display("FAIL ign_lo got %h exp 0000002a", bus.lo); end
    extra_done = 0;
    extra_busy = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.done) extra_done++;
      if (bus.busy) extra_busy++;
    end
    checks++; if (extra_done !== 0) begin errors++; $display("FAIL ign_extra_done got %0d exp 0", extra_done); end
    checks++; if (extra_busy !== 0) begin errors++; $display("FAIL ign_extra_busy got %0d exp 0", extra_busy); end
  endtask

  task automatic test_mt_write();
    int n, bc;
    bus.mthi    = 1'b1;
    bus.mtlo    = 1'b1;
    bus.mt_data = 32'hA5A5_A5A5;
    step();
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    checks++; if (bus.hi !== 32'hA5A5_A5A5) begin errors++; $display("FAIL mt_both_hi got %h exp a5a5a5a5", bus.hi); end
    checks++; if (bus.lo !== 32'hA5A5_A5A5) begin errors++; $display("FAIL mt_both_lo got %h exp a5a5a5a5", bus.lo); end
    bus.mthi    = 1'b1;
    bus.mt_data = 32'h0000_0005;
    step();
    bus.mthi = 1'b0;
    checks++; if (bus.hi !== 32'h0000_0005) begin errors++; $display("FAIL mthi_only_hi got %h exp 00000005", bus.hi); end
    checks++; if (bus.lo !== 32'hA5A5_A5A5) begin errors++; $display("FAIL mthi_only_lo got %h exp a5a5a5a5", bus.lo); end
    bus.mtlo    = 1'b1;
    bus.mt_data = 32'h1111_1111;
    launch(OP_MULTU, 32'd2, 32'd3);
    bus.mtlo = 1'b0;
    checks++; if (bus.lo !== 32'hA5A5_A5A5) begin errors++; $display("FAIL start_mt_drop_lo got %h exp a5a5a5a5", bus.lo); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL start_mt_busy got %b exp 1", bus.busy); end
    wait_done(n, bc);
    checks++; if (bus.lo !== 32'd6) begin errors++; $display("FAIL start_mt_result_lo got %h exp 00000006", bus.lo); end
    checks++; if (bus.hi !== 32'd0) begin errors++; $display("FAIL start_mt_result_hi got %h exp 00000000", bus.hi); end
    step();
  endtask

  task automatic test_reset_mid_op();
    int cyc, seen_done, n, bc;
    bus.mthi    = 1'b1;
    bus.mtlo    = 1'b1;
    bus.mt_data = 32'hA5A5_A5A5;
    step();
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    launch(OP_DIVU, 32'd1000, 32'd3);
    for (cyc = 1; cyc < 15; cyc++) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", bus.busy); end
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL midrst_hi got %h exp 00000000", bus.hi); end
    checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL midrst_lo got %h exp 00000000", bus.lo); end
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) seen_done++;
      step();
    end
    checks++; if (seen_done !== 0) begin errors++; $display("FAIL midrst_done got %0d exp 0", seen_done); end
    launch(OP_MULTU, 32'd3, 32'd3);
    wait_done(n, bc);
    checks++; if (n !== 33) begin errors++; $display("FAIL postrst_latency got %0d exp 33", n); end
    checks++; if (bus.lo !== 32'd9) begin errors++; $display("FAIL postrst_lo got %h exp 00000009", bus.lo); end
    checks++; if (bus.hi !== 32'd0) begin errors++; $display("FAIL postrst_hi got %h exp 00000000", bus.hi); end
    step();
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.op        = 2'b00;
    bus.operand_a = '0;
    bus.operand_b = '0;
    bus.mthi      = 1'b0;
    bus.mtlo      = 1'b0;
    bus.mt_data   = '0;
    test_reset();
    test_multu_max();
    test_mult_signed();
    test_divide();
    test_div_boundaries();
    test_ignored_inputs();
    test_mt_write();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
